mem_access_ctrl: RTL and testbench

//  Upstream front end of the single-port unified instruction/data RAM (12-bit word address, 1-cycle registered read, no read on write cycles).

---
 rtl/mem_access_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Front end of the single-port unified I/D RAM: arbitrates fetch and data ports,
// converts byte to word addresses, does sub-word stores by read-modify-write.
module mem_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter bit DPRIO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_rdy,
  output logic [31:0]       if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_rdy,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_RD_A = 3'd2,
    S_RD_D = 3'd3,
    S_RESP = 3'd4,
    S_WR   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_lane;
  logic [1:0]          r_size;
  logic                r_we;
  logic                r_uns;
  logic                r_src_d;
  logic [31:0]         r_wdata;
  logic                r_if_rdy;
  logic [31:0]         r_if_data;
  logic                r_d_rdy;
  logic [31:0]         r_d_rdata;
  logic                r_d_misalign;

  logic                w_pick_d;
  logic                w_pick_if;
  logic                w_misalign;
  logic                w_word_store;
  logic                w_unused;

  // Lane extraction with sign/zero extension for loads.
  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old word with the right-justified store data.
  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] lane, input logic [1:0] sz);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00: begin
        case (lane)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign w_pick_d     = d_req & (DPRIO | ~if_req);
  assign w_pick_if    = if_req & ~w_pick_d;
  assign w_misalign   = (d_size == 2'b11) | ((d_size == 2'b01) & d_addr[0]) |
                        ((d_size == 2'b10) & (d_addr[1:0] != 2'b00));
  assign w_word_store = d_we & (d_size == 2'b10);
  assign w_unused     = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_d) begin
          if (w_misalign)        w_next = S_ERR;
          else if (w_word_store) w_next = S_WR;
          else                   w_next = S_RD_A;
        end else if (w_pick_if) begin
          w_next = S_RD_A;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD_A:  w_next = S_RD_D;
      S_RD_D:  w_next = (r_src_d & r_we) ? S_WR : S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_WR:    w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, read capture/merge and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_lane       <= 2'b00;
      r_size       <= 2'b00;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_src_d      <= 1'b0;
      r_wdata      <= 32'h0000_0000;
      r_if_rdy     <= 1'b0;
      r_if_data    <= 32'h0000_0000;
      r_d_rdy      <= 1'b0;
      r_d_rdata    <= 32'h0000_0000;
      r_d_misalign <= 1'b0;
    end else begin
      r_if_rdy     <= 1'b0;
      r_d_rdy      <= 1'b0;
      r_d_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_d) begin
            r_addr  <= d_addr[ADDR_W+1:2];
            r_lane  <= d_addr[1:0];
            r_size  <= d_size;
            r_we    <= d_we;
            r_uns   <= d_unsigned;
            r_src_d <= 1'b1;
            r_wdata <= d_wdata;
            if (w_misalign | w_word_store) begin
              r_d_rdy      <= 1'b1;
              r_d_misalign <= w_misalign;
              r_d_rdata    <= 32'h0000_0000;
            end
          end else if (w_pick_if) begin
            r_addr  <= if_addr[ADDR_W+1:2];
            r_lane  <= 2'b00;
            r_size  <= 2'b10;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_src_d <= 1'b0;
          end
        end
        S_RD_D: begin
          if (r_src_d & r_we) begin
            r_wdata   <= f_merge(mem_dout, r_wdata, r_lane, r_size);
            r_d_rdy   <= 1'b1;
            r_d_rdata <= 32'h0000_0000;
          end else if (r_src_d) begin
            r_d_rdata <= f_load(mem_dout, r_lane, r_size, r_uns);
            r_d_rdy   <= 1'b1;
          end else begin
            r_if_data <= mem_dout;
            r_if_rdy  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Reset gates the write strobe so a reset landing on WR never commits.
  assign mem_we     = (r_state == S_WR) & rst_n;
  assign mem_addr   = (r_state == S_IDLE) ? '0 : r_addr;
  assign mem_din    = r_wdata;
  assign if_rdy     = r_if_rdy;
  assign if_data    = r_if_data;
  assign d_rdy      = r_d_rdy;
  assign d_rdata    = r_d_rdata;
  assign d_misalign = r_d_misalign;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (DPRIO=0 and 1) with a RAM stub each,
// checked every cycle against a transaction-level model of the memory and handshake.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req_a [2];
  logic [31:0] if_addr;
  logic        d_req_a [2];
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        if_rdy_a [2];
  logic [31:0] if_data_a [2];
  logic        d_rdy_a [2];
  logic [31:0] d_rdata_a [2];
  logic        d_mis_a [2];
  logic        mem_we_a [2];
  logic [11:0] mem_addr_a [2];
  logic [31:0] mem_din_a [2];
  logic [31:0] mem_dout_a [2];

  logic [31:0] ram [2][4096];
  logic [31:0] model_mem [4096];
  logic        preload;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        checking = 1'b0;
  int          exp_d_cyc [2];
  int          exp_if_cyc [2];
  int          exp_wr_cyc [2];
  logic [31:0] exp_d_data;
  logic [31:0] exp_if_data;
  logic [31:0] exp_wr_data;
  logic [11:0] exp_wr_addr;
  logic        exp_mis;
  logic [31:0] last_d_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_ctrl #(.ADDR_W(12), .DPRIO((g == 1) ? 1'b1 : 1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req_a[g]), .if_addr(if_addr), .if_rdy(if_rdy_a[g]), .if_data(if_data_a[g]),
      .d_req(d_req_a[g]), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_rdy(d_rdy_a[g]), .d_rdata(d_rdata_a[g]),
      .d_misalign(d_mis_a[g]), .mem_we(mem_we_a[g]), .mem_addr(mem_addr_a[g]),
      .mem_din(mem_din_a[g]), .mem_dout(mem_dout_a[g])
    );
  end

  // RAM stubs: registered read, no read on write cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (preload) begin
        ram[k][0] <= 32'h0000_0000;
        ram[k][4] <= 32'h0000_0000;
        ram[k][8] <= 32'hCAFE_F00D;
      end else if (mem_we_a[k]) begin
        ram[k][mem_addr_a[k]] <= mem_din_a[k];
      end else begin
        mem_dout_a[k] <= ram[k][mem_addr_a[k]];
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [dprio=%0d] cyc=%0d: got %h, expected %h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * a[1:0])) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * a[1])) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] mask;
    int sh;
    if (sz == 2'b10) return wd;
    sh   = (sz == 2'b00) ? 8 * a[1:0] : 16 * a[1];
    mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Cycle-by-cycle comparison of both instances against the expected events.
  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        chk("if_rdy", k, 32'(if_rdy_a[k]), 32'(cyc == exp_if_cyc[k]));
        chk("d_rdy", k, 32'(d_rdy_a[k]), 32'(cyc == exp_d_cyc[k]));
        chk("mem_we", k, 32'(mem_we_a[k]), 32'(cyc == exp_wr_cyc[k]));
        if (cyc == exp_d_cyc[k]) begin
          chk("d_rdata", k, d_rdata_a[k], exp_d_data);
          chk("d_misalign", k, 32'(d_mis_a[k]), 32'(exp_mis));
        end
        if (cyc == exp_if_cyc[k]) chk("if_data", k, if_data_a[k], exp_if_data);
        if (cyc == exp_wr_cyc[k]) begin
          chk("mem_addr", k, 32'(mem_addr_a[k]), 32'(exp_wr_addr));
          chk("mem_din", k, mem_din_a[k], exp_wr_data);
        end
        if (d_rdy_a[k]) last_d_rdata[k] = d_rdata_a[k];
      end
    end
  end

  // One data access on both instances; the requester holds d_req until its d_rdy.
  task automatic data_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    int          lat;
    logic        mis;
    logic [31:0] nw;
    @(posedge clk); #1;
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_mis    = mis;
    exp_d_data = 32'h0000_0000;
    if (mis) begin
      lat = 1;
    end else if (we) begin
      lat = (sz == 2'b10) ? 1 : 3;
      nw  = model_store(model_mem[a[13:2]], wd, a, sz);
      model_mem[a[13:2]] = nw;
      exp_wr_addr = a[13:2];
      exp_wr_data = nw;
      for (int k = 0; k < 2; k++) exp_wr_cyc[k] = cyc + lat;
    end else begin
      lat = 3;
      exp_d_data = model_load(model_mem[a[13:2]], a, sz, uns);
    end
    for (int k = 0; k < 2; k++) begin
      exp_d_cyc[k] = cyc + lat;
      d_req_a[k]   = 1'b1;
    end
    d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
    repeat (lat + 1) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) d_req_a[k] = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_if_rdy"}, k, 32'(if_rdy_a[k]), 32'h0);
      chk({nm, "_d_rdy"}, k, 32'(d_rdy_a[k]), 32'h0);
      chk({nm, "_d_misalign"}, k, 32'(d_mis_a[k]), 32'h0);
      chk({nm, "_mem_we"}, k, 32'(mem_we_a[k]), 32'h0);
      chk({nm, "_if_data"}, k, if_data_a[k], 32'h0);
      chk({nm, "_d_rdata"}, k, d_rdata_a[k], 32'h0);
      chk({nm, "_mem_addr"}, k, 32'(mem_addr_a[k]), 32'h0);
      chk({nm, "_mem_din"}, k, mem_din_a[k], 32'h0);
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0; preload = 1'b1;
    if_addr = 32'h0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      if_req_a[k] = 1'b0; d_req_a[k] = 1'b0;
      exp_d_cyc[k] = -1; exp_if_cyc[k] = -1; exp_wr_cyc[k] = -1;
      last_d_rdata[k] = 32'h0;
    end
    model_mem[0] = 32'h0000_0000;
    model_mem[4] = 32'h0000_0000;
    model_mem[8] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    check_all_zero("reset");
    rst_n = 1'b1;
    checking = 1'b1;

    // Word store then word load.
    data_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    data_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_0x10", 1, last_d_rdata[1], 32'hDEAD_BEEF);

    // Byte store by RMW, signed and unsigned byte loads.
    data_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    data_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("lb_0x11", 1, last_d_rdata[1], 32'hFFFF_FFAA);
    data_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("lbu_0x11", 1, last_d_rdata[1], 32'h0000_00AA);

    // Halfword store, loads from both half lanes.
    data_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
    data_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh_0x12", 1, last_d_rdata[1], 32'h0000_1234);
    data_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("lh_0x10", 1, last_d_rdata[1], 32'hFFFF_AAEF);
    chk("ram4_after_sh", 1, ram[1][4], 32'h1234_AAEF);

    // Simultaneous fetch and load: priority decides the order per instance.
    @(posedge clk); #1;
    c = cyc;
    exp_mis = 1'b0;
    exp_d_data  = model_mem[4];
    exp_if_data = model_mem[8];
    exp_d_cyc[1] = c + 3; exp_if_cyc[1] = c + 7;
    exp_if_cyc[0] = c + 3; exp_d_cyc[0] = c + 7;
    if_addr = 32'h20; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h10;
    for (int k = 0; k < 2; k++) begin
      if_req_a[k] = 1'b1; d_req_a[k] = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
    d_req_a[1] = 1'b0; if_req_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if_req_a[1] = 1'b0; d_req_a[0] = 1'b0;

    // Misaligned and reserved-size accesses are rejected without RAM effect.
    data_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    data_op(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5678);
    data_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("ram4_after_misalign", 1, ram[1][4], 32'h1234_AAEF);

    // Reset landing on the WR cycle of a byte store.
    @(posedge clk); #1;
    c = cyc;
    exp_mis = 1'b0; exp_d_data = 32'h0;
    for (int k = 0; k < 2; k++) begin
      exp_d_cyc[k] = c + 3; d_req_a[k] = 1'b1;
    end
    d_we = 1'b1; d_size = 2'b00; d_unsigned = 1'b0; d_addr = 32'h11; d_wdata = 32'h0000_0055;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk("we_in_reset", k, 32'(mem_we_a[k]), 32'h0);
    @(posedge clk); #1;
    check_all_zero("after_wr_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) d_req_a[k] = 1'b0;
    data_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_after_reset", 1, last_d_rdata[1], 32'h1234_AAEF);
    for (int k = 0; k < 2; k++) begin
      chk("ram4_final", k, ram[k][4], model_mem[4]);
      chk("ram8_final", k, ram[k][8], 32'hCAFE_F00D);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
